// File: rtl/v_cu_pkg.sv
// v_cu_pkg: shared types for the vector control unit.
//   sew_e       - element width encoding used on the allocator/port-group handshake
//   pgs_state_e - port_group_sequencer FSM states
//   sew_norm    - folds the reserved sew code 3 onto 32-bit elements
package v_cu_pkg;

   typedef enum logic [1:0] {
      SEW8  = 2'd0,
      SEW16 = 2'd1,
      SEW32 = 2'd2
   } sew_e;

   typedef enum logic [1:0] {
      PGS_IDLE  = 2'd0,
      PGS_ISSUE = 2'd1,
      PGS_DRAIN = 2'd2
   } pgs_state_e;

   function automatic sew_e sew_norm(input logic [1:0] s);
      return (s == 2'd3) ? SEW32 : sew_e'(s);
   endfunction

endpackage

// File: rtl/pgs_delay_line.sv
// pgs_delay_line: PIPE_LAT-stage shift register tracking rows between read
// issue and write issue. Advances every cycle; an empty push is a bubble.
// Ports:
//   clk, rstn                      - clock, async active-low reset
//   push_vld_i/row_i/be_i          - entry entering stage 0
//   out_vld_o/row_o/be_o           - entry leaving the last stage (the write)
//   any_valid_o                    - a valid entry is still in flight after
//                                    this cycle's shift (stages 0..PIPE_LAT-2)
module pgs_delay_line #(
   parameter int PIPE_LAT = 4,
   parameter int ADDR_W   = 8,
   parameter int BE_W     = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              push_vld_i,
   input  logic [ADDR_W-1:0] push_row_i,
   input  logic [BE_W-1:0]   push_be_i,
   output logic              out_vld_o,
   output logic [ADDR_W-1:0] out_row_o,
   output logic [BE_W-1:0]   out_be_o,
   output logic              any_valid_o
);

   logic [PIPE_LAT-1:0]             vld_q, vld_d;
   logic [PIPE_LAT-1:0][ADDR_W-1:0] row_q, row_d;
   logic [PIPE_LAT-1:0][BE_W-1:0]   be_q,  be_d;

   always_comb begin
      vld_d = vld_q;
      row_d = row_q;
      be_d  = be_q;
      for (int i = PIPE_LAT-1; i > 0; i--) begin
         vld_d[i] = vld_q[i-1];
         row_d[i] = row_q[i-1];
         be_d[i]  = be_q[i-1];
      end
      vld_d[0] = push_vld_i;
      row_d[0] = push_row_i;
      be_d[0]  = push_be_i;
   end

   // The last stage is being presented as a write this cycle, so it is not
   // counted: the sequencer can leave DRAIN as the final write goes out and
   // raise done in the very next cycle.
   always_comb begin
      any_valid_o = 1'b0;
      for (int i = 0; i < PIPE_LAT-1; i++) any_valid_o = any_valid_o | vld_q[i];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_q <= '0;
         row_q <= '0;
         be_q  <= '0;
      end else begin
         vld_q <= vld_d;
         row_q <= row_d;
         be_q  <= be_d;
      end
   end

   assign out_vld_o = vld_q[PIPE_LAT-1];
   assign out_row_o = row_q[PIPE_LAT-1];
   assign out_be_o  = be_q[PIPE_LAT-1];

endmodule

// File: rtl/port_group_sequencer.sv
// port_group_sequencer: per-port-group execution sequencer. Accepts a start
// while idle, issues one VRF read row per unstalled cycle, delays each row
// PIPE_LAT cycles and issues the matching write with byte enables, then
// pulses done and returns idle.
// Ports:
//   clk, rstn                         - clock, async active-low reset
//   start_i, vl_i, sew_i, *_base_i    - instruction from the allocator
//   port_rdy_o                        - idle, start accepted
//   rd_vld_o, rd_vs1/vs2_row_o        - read row request
//   rd_stall_i                        - read backpressure
//   wr_vld_o, wr_row_o, wr_byte_en_o  - write row
//   done_o                            - instruction retired (1-cycle pulse)
module port_group_sequencer
   import v_cu_pkg::*;
#(
   parameter int LANES    = 8,
   parameter int PIPE_LAT = 4,
   parameter int VL_W     = 12,
   parameter int ADDR_W   = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start_i,
   input  logic [VL_W-1:0]      vl_i,
   input  logic [1:0]           sew_i,
   input  logic [ADDR_W-1:0]    vs1_base_i,
   input  logic [ADDR_W-1:0]    vs2_base_i,
   input  logic [ADDR_W-1:0]    vd_base_i,
   output logic                 port_rdy_o,
   output logic                 rd_vld_o,
   output logic [ADDR_W-1:0]    rd_vs1_row_o,
   output logic [ADDR_W-1:0]    rd_vs2_row_o,
   input  logic                 rd_stall_i,
   output logic                 wr_vld_o,
   output logic [ADDR_W-1:0]    wr_row_o,
   output logic [4*LANES-1:0]   wr_byte_en_o,
   output logic                 done_o
);

   localparam int BE_W     = 4*LANES;
   localparam int LG_LANES = $clog2(LANES);

   pgs_state_e        state_q, state_d;
   logic [VL_W-1:0]   k_q, k_d;
   logic [VL_W-1:0]   vl_q, vl_d;
   sew_e              sew_q, sew_d;
   logic [ADDR_W-1:0] vs1_q, vs1_d, vs2_q, vs2_d, vd_q, vd_d;
   logic              done_q, done_d;

   int                sh;          // log2(elements per row)
   logic [VL_W:0]     epr_m1;      // elements per row - 1
   logic [VL_W:0]     nrows;
   logic              last_row;
   int                rem_bytes;   // bytes valid in the last row, 0 = full
   logic [BE_W-1:0]   row_be;

   logic              push_vld;
   logic [ADDR_W-1:0] push_row;
   logic [BE_W-1:0]   push_be;
   logic              any_valid;

   // Row geometry; epr is a power of two so division and modulo are shift/mask.
   always_comb begin
      sh        = LG_LANES + 2 - int'(sew_q);
      epr_m1    = (VL_W+1)'((1 << sh) - 1);
      nrows     = ({1'b0, vl_q} + epr_m1) >> sh;
      last_row  = ({1'b0, k_q} == (nrows - (VL_W+1)'(1)));
      rem_bytes = int'(vl_q & epr_m1[VL_W-1:0]) << int'(sew_q);
      row_be    = '1;
      if (last_row && (rem_bytes != 0)) begin
         for (int i = 0; i < BE_W; i++) row_be[i] = (i < rem_bytes);
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      vl_d    = vl_q;
      sew_d   = sew_q;
      vs1_d   = vs1_q;
      vs2_d   = vs2_q;
      vd_d    = vd_q;
      done_d  = 1'b0;
      case (state_q)
         PGS_IDLE: begin
            if (start_i) begin
               vl_d    = vl_i;
               sew_d   = sew_norm(sew_i);
               vs1_d   = vs1_base_i;
               vs2_d   = vs2_base_i;
               vd_d    = vd_base_i;
               k_d     = '0;
               // vl=0 has nothing to read: one DRAIN cycle, then done.
               state_d = (vl_i == '0) ? PGS_DRAIN : PGS_ISSUE;
            end
         end
         PGS_ISSUE: begin
            if (!rd_stall_i) begin
               k_d = k_q + 1'b1;
               if (last_row) state_d = PGS_DRAIN;
            end
         end
         PGS_DRAIN: begin
            if (!any_valid) begin
               state_d = PGS_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = PGS_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= PGS_IDLE;
         k_q     <= '0;
         vl_q    <= '0;
         sew_q   <= SEW8;
         vs1_q   <= '0;
         vs2_q   <= '0;
         vd_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         vl_q    <= vl_d;
         sew_q   <= sew_d;
         vs1_q   <= vs1_d;
         vs2_q   <= vs2_d;
         vd_q    <= vd_d;
         done_q  <= done_d;
      end
   end

   assign port_rdy_o   = (state_q == PGS_IDLE);
   assign rd_vld_o     = (state_q == PGS_ISSUE);
   assign rd_vs1_row_o = rd_vld_o ? vs1_q + ADDR_W'(k_q) : '0;
   assign rd_vs2_row_o = rd_vld_o ? vs2_q + ADDR_W'(k_q) : '0;
   assign done_o       = done_q;

   // A stalled read enters the delay line as an all-zero bubble.
   assign push_vld = rd_vld_o && !rd_stall_i;
   assign push_row = push_vld ? vd_q + ADDR_W'(k_q) : '0;
   assign push_be  = push_vld ? row_be : '0;

   pgs_delay_line #(
      .PIPE_LAT (PIPE_LAT),
      .ADDR_W   (ADDR_W),
      .BE_W     (BE_W)
   ) u_dly (
      .clk         (clk),
      .rstn        (rstn),
      .push_vld_i  (push_vld),
      .push_row_i  (push_row),
      .push_be_i   (push_be),
      .out_vld_o   (wr_vld_o),
      .out_row_o   (wr_row_o),
      .out_be_o    (wr_byte_en_o),
      .any_valid_o (any_valid)
   );

endmodule

// File: tb/tb_port_group_sequencer.sv
// Directed bench for port_group_sequencer (LANES=8, PIPE_LAT=4).
// Cycle c's outputs are sampled at the falling edge inside cycle c; inputs for
// cycle c are driven at that same falling edge.
module tb_port_group_sequencer;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start_i;
   logic [11:0] vl_i;
   logic [1:0]  sew_i;
   logic [7:0]  vs1_base_i, vs2_base_i, vd_base_i;
   logic        port_rdy_o, rd_vld_o;
   logic [7:0]  rd_vs1_row_o, rd_vs2_row_o;
   logic        rd_stall_i;
   logic        wr_vld_o;
   logic [7:0]  wr_row_o;
   logic [31:0] wr_byte_en_o;
   logic        done_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   port_group_sequencer #(.LANES(8), .PIPE_LAT(4), .VL_W(12), .ADDR_W(8)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .start_i      (start_i),
      .vl_i         (vl_i),
      .sew_i        (sew_i),
      .vs1_base_i   (vs1_base_i),
      .vs2_base_i   (vs2_base_i),
      .vd_base_i    (vd_base_i),
      .port_rdy_o   (port_rdy_o),
      .rd_vld_o     (rd_vld_o),
      .rd_vs1_row_o (rd_vs1_row_o),
      .rd_vs2_row_o (rd_vs2_row_o),
      .rd_stall_i   (rd_stall_i),
      .wr_vld_o     (wr_vld_o),
      .wr_row_o     (wr_row_o),
      .wr_byte_en_o (wr_byte_en_o),
      .done_o       (done_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s c%0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // Rows and byte enables are compared only when their valid is expected high.
   task automatic expect_cyc(input string tag, input logic rdy, input logic rv,
                             input logic [7:0] r1, input logic [7:0] r2,
                             input logic wv, input logic [7:0] wr,
                             input logic [31:0] be, input logic dn);
      chk({tag, ".rdy"}, 64'(port_rdy_o), 64'(rdy));
      chk({tag, ".rd_vld"}, 64'(rd_vld_o), 64'(rv));
      if (rv) begin
         chk({tag, ".vs1"}, 64'(rd_vs1_row_o), 64'(r1));
         chk({tag, ".vs2"}, 64'(rd_vs2_row_o), 64'(r2));
      end
      chk({tag, ".wr_vld"}, 64'(wr_vld_o), 64'(wv));
      if (wv) begin
         chk({tag, ".wr_row"}, 64'(wr_row_o), 64'(wr));
         chk({tag, ".wr_be"}, 64'(wr_byte_en_o), 64'(be));
      end
      chk({tag, ".done"}, 64'(done_o), 64'(dn));
   endtask

   task automatic nxt();
      @(negedge clk);
      start_i = 1'b0;
      cyc++;
   endtask

   // Drives a start in the current cycle, which becomes cycle 0.
   task automatic start(input logic [11:0] vl, input logic [1:0] sew,
                        input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] bd);
      cyc        = 0;
      start_i    = 1'b1;
      vl_i       = vl;
      sew_i      = sew;
      vs1_base_i = b1;
      vs2_base_i = b2;
      vd_base_i  = bd;
   endtask

   initial begin
      rstn = 1'b0; start_i = 1'b0; vl_i = '0; sew_i = '0;
      vs1_base_i = '0; vs2_base_i = '0; vd_base_i = '0; rd_stall_i = 1'b0;

      // Reset state
      @(negedge clk);
      expect_cyc("rst", 1, 0, 0, 0, 0, 0, 0, 0);
      chk("rst.vs1", 64'(rd_vs1_row_o), 64'h0);
      chk("rst.wr_row", 64'(wr_row_o), 64'h0);
      chk("rst.wr_be", 64'(wr_byte_en_o), 64'h0);
      rstn = 1'b1;
      nxt();

      // vl=20 sew=32b: 3 rows, last row 4 elements = 16 bytes
      start(12'd20, 2'd2, 8'h10, 8'h30, 8'h20);
      expect_cyc("a", 1, 0, 0, 0, 0, 0, 0, 0);
      nxt(); expect_cyc("a", 0, 1, 8'h10, 8'h30, 0, 0, 0, 0);
      nxt(); expect_cyc("a", 0, 1, 8'h11, 8'h31, 0, 0, 0, 0);
      nxt(); expect_cyc("a", 0, 1, 8'h12, 8'h32, 0, 0, 0, 0);
      nxt(); expect_cyc("a", 0, 0, 0, 0, 0, 0, 0, 0);
      nxt(); expect_cyc("a", 0, 0, 0, 0, 1, 8'h20, 32'hFFFF_FFFF, 0);
      nxt(); expect_cyc("a", 0, 0, 0, 0, 1, 8'h21, 32'hFFFF_FFFF, 0);
      nxt(); expect_cyc("a", 0, 0, 0, 0, 1, 8'h22, 32'h0000_FFFF, 0);
      nxt(); expect_cyc("a", 1, 0, 0, 0, 0, 0, 0, 1);
      nxt(); expect_cyc("a", 1, 0, 0, 0, 0, 0, 0, 0);

      // vl=64 sew=8b: 2 full rows
      start(12'd64, 2'd0, 8'h40, 8'h50, 8'h60);
      nxt(); expect_cyc("b", 0, 1, 8'h40, 8'h50, 0, 0, 0, 0);
      nxt(); expect_cyc("b", 0, 1, 8'h41, 8'h51, 0, 0, 0, 0);
      nxt(); expect_cyc("b", 0, 0, 0, 0, 0, 0, 0, 0);
      nxt(); expect_cyc("b", 0, 0, 0, 0, 0, 0, 0, 0);
      nxt(); expect_cyc("b", 0, 0, 0, 0, 1, 8'h60, 32'hFFFF_FFFF, 0);
      nxt(); expect_cyc("b", 0, 0, 0, 0, 1, 8'h61, 32'hFFFF_FFFF, 0);
      nxt(); expect_cyc("b", 1, 0, 0, 0, 0, 0, 0, 1);
      nxt();

      // Same with stall in cycles 2-3 and an ignored start in cycle 3
      start(12'd64, 2'd0, 8'h40, 8'h50, 8'h60);
      nxt(); expect_cyc("c", 0, 1, 8'h40, 8'h50, 0, 0, 0, 0);
      nxt(); rd_stall_i = 1'b1;
      expect_cyc("c", 0, 1, 8'h41, 8'h51, 0, 0, 0, 0);
      nxt(); start_i = 1'b1; vl_i = 12'd0;
      expect_cyc("c", 0, 1, 8'h41, 8'h51, 0, 0, 0, 0);
      nxt(); rd_stall_i = 1'b0;
      expect_cyc("c", 0, 1, 8'h41, 8'h51, 0, 0, 0, 0);
      nxt(); expect_cyc("c", 0, 0, 0, 0, 1, 8'h60, 32'hFFFF_FFFF, 0);
      nxt(); expect_cyc("c", 0, 0, 0, 0, 0, 0, 0, 0);
      nxt(); expect_cyc("c", 0, 0, 0, 0, 0, 0, 0, 0);
      nxt(); expect_cyc("c", 0, 0, 0, 0, 1, 8'h61, 32'hFFFF_FFFF, 0);
      nxt(); expect_cyc("c", 1, 0, 0, 0, 0, 0, 0, 1);
      nxt(); expect_cyc("c", 1, 0, 0, 0, 0, 0, 0, 0);

      // vl=0
      start(12'd0, 2'd2, 8'h01, 8'h02, 8'h03);
      nxt(); expect_cyc("d", 0, 0, 0, 0, 0, 0, 0, 0);
      nxt(); expect_cyc("d", 1, 0, 0, 0, 0, 0, 0, 1);
      nxt(); expect_cyc("d", 1, 0, 0, 0, 0, 0, 0, 0);

      // Row address wrap-around
      start(12'd16, 2'd2, 8'hFF, 8'h7F, 8'hFE);
      nxt(); expect_cyc("e", 0, 1, 8'hFF, 8'h7F, 0, 0, 0, 0);
      nxt(); expect_cyc("e", 0, 1, 8'h00, 8'h80, 0, 0, 0, 0);
      nxt(); nxt();
      nxt(); expect_cyc("e", 0, 0, 0, 0, 1, 8'hFE, 32'hFFFF_FFFF, 0);
      nxt(); expect_cyc("e", 0, 0, 0, 0, 1, 8'hFF, 32'hFFFF_FFFF, 0);
      nxt(); expect_cyc("e", 1, 0, 0, 0, 0, 0, 0, 1);
      nxt();

      // sew=16b, vl=5: one row, 10 bytes enabled
      start(12'd5, 2'd1, 8'h03, 8'h13, 8'h33);
      nxt(); expect_cyc("f", 0, 1, 8'h03, 8'h13, 0, 0, 0, 0);
      nxt(); nxt(); nxt();
      nxt(); expect_cyc("f", 0, 0, 0, 0, 1, 8'h33, 32'h0000_03FF, 0);
      nxt(); expect_cyc("f", 1, 0, 0, 0, 0, 0, 0, 1);
      nxt();

      // sew=3 behaves as 32b: vl=5 -> 20 bytes enabled
      start(12'd5, 2'd3, 8'h04, 8'h14, 8'h44);
      nxt(); expect_cyc("g", 0, 1, 8'h04, 8'h14, 0, 0, 0, 0);
      nxt(); nxt(); nxt();
      nxt(); expect_cyc("g", 0, 0, 0, 0, 1, 8'h44, 32'h000F_FFFF, 0);
      nxt(); expect_cyc("g", 1, 0, 0, 0, 0, 0, 0, 1);
      nxt();

      // Async reset in cycle 3 of a 5-row instruction
      start(12'd40, 2'd2, 8'h08, 8'h18, 8'h28);
      nxt(); expect_cyc("h", 0, 1, 8'h08, 8'h18, 0, 0, 0, 0);
      nxt(); expect_cyc("h", 0, 1, 8'h09, 8'h19, 0, 0, 0, 0);
      nxt(); expect_cyc("h", 0, 1, 8'h0A, 8'h1A, 0, 0, 0, 0);
      #2 rstn = 1'b0;
      #1;
      expect_cyc("h.rst", 1, 0, 0, 0, 0, 0, 0, 0);
      chk("h.rst.vs1", 64'(rd_vs1_row_o), 64'h0);
      chk("h.rst.wr_be", 64'(wr_byte_en_o), 64'h0);
      nxt(); rstn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         nxt(); expect_cyc("h.post", 1, 0, 0, 0, 0, 0, 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/port_group_sequencer.md
# port_group_sequencer

Per-port-group execution sequencer on the responder side of the allocator/port-group handshake in the vector control unit. It accepts a one-cycle `start_i` from the allocator while advertising `port_rdy_o`, then steps the vector instruction through the group's VRF rows. It issues one read row per cycle, delays each row through a fixed-latency pipeline tracker, and issues the matching VRF write with a byte enable. It reasserts `port_rdy_o` when the last write retires. One instance is built per write port group (W_PORTS_NUM instances).

## Interface
- `LANES`, default 8: 32-bit lanes per port group; a VRF row is 4*LANES bytes.
- `PIPE_LAT`, default 4: cycles from read issue to write issue for a row; minimum 1.
- `VL_W`, default 12: width of the vector-length field.
- `ADDR_W`, default 8: VRF row address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `start_i` in 1: one-cycle start from the allocator. It is honoured only while `port_rdy_o`=1 and ignored otherwise.
- `vl_i` in VL_W: element count, sampled on an accepted start.
- `sew_i` in 2: element width, 0=8b, 1=16b, 2=32b; 3 is treated as 2. Sampled on start.
- `vs1_base_i`, `vs2_base_i`, `vd_base_i` in ADDR_W each: starting rows, sampled on start.
- `port_rdy_o` out 1: group idle and able to accept `start_i`.
- `rd_vld_o` out 1: read row request this cycle.
- `rd_vs1_row_o`, `rd_vs2_row_o` out ADDR_W: rows being read.
- `rd_stall_i` in 1: VRF read backpressure. While it is high, no read is consumed and the row counter holds.
- `wr_vld_o` out 1: write row this cycle.
- `wr_row_o` out ADDR_W: destination row.
- `wr_byte_en_o` out 4*LANES: byte enables for the write.
- `done_o` out 1: one-cycle pulse when the instruction has fully retired.

## Operation
- States:
  - IDLE: `port_rdy_o`=1.
  - ISSUE: reads outstanding.
  - DRAIN: waiting for the pipeline to empty.
- IDLE → ISSUE on `start_i`. Registers vl, sew and bases; clears the row counter.
- Elements per row: `epr` = LANES*(4>>sew).
- Rows to issue: `nrows` = ceil(vl/epr), computed with a shift (epr is a power of two).
- Last-row element count: `rem` = vl mod epr; 0 means a full row.
- ISSUE:
  - `rd_vld_o`=1 each cycle. The read counts as consumed when `rd_stall_i`=0, which increments row k.
  - Rows read are base+k, modulo 2^ADDR_W (wrap-around is allowed).
  - Each consumed read pushes {valid, vd_base+k, byte_en} into the PIPE_LAT-deep delay line. A stalled cycle pushes a bubble.
  - byte_en is all ones, except on the last row, where it is the low (rem<<sew) bits set.
  - After the read of row nrows-1 is consumed → DRAIN.
- DRAIN: when the delay line holds no valid entry → IDLE. The `done_o` pulse and `port_rdy_o`=1 occur together in the first IDLE cycle.
- `vl_i`=0: ISSUE is skipped. The block sits in DRAIN for one cycle with no reads or writes, so `port_rdy_o` is low for exactly one cycle, then `done_o` pulses.
- `start_i` while busy: ignored. No state change.

## Timing
- Reset values: `port_rdy_o`=1; `rd_vld_o`, `wr_vld_o` and `done_o` = 0; all row, byte-enable and counter outputs 0; delay line cleared.
- Reset asserted mid-operation aborts the instruction immediately. No `done_o` is produced.
- Accepted start in cycle 0:
  - `port_rdy_o`=0 from cycle 1.
  - First `rd_vld_o` in cycle 1.
  - With no stalls, row k is read in cycle 1+k and written in cycle 1+k+PIPE_LAT.
  - `done_o` and `port_rdy_o`=1 occur in cycle 2+(nrows-1)+PIPE_LAT.
- Each stall cycle delays all subsequent reads, writes and `done_o` by one cycle.
- Writes are never stalled. The delay line advances every cycle.
- Read and write can both be active in the same cycle.

## Structure
- Goes in the shared `v_cu_pkg`: the sew encoding enum (`SEW8`, `SEW16`, `SEW32`) and the state enum `pgs_state_e`.
- Sub-module `pgs_delay_line`: a parameterized PIPE_LAT-stage shift register carrying {valid, row, byte_en}. It has asynchronous reset and exposes an `any_valid` output.

## Test plan
- LANES=8, PIPE_LAT=4, vl=20, sew=2, vs1=0x10, vs2=0x30, vd=0x20, start in cycle 0:
  - Reads rows 0x10/0x30, 0x11/0x31, 0x12/0x32 in cycles 1–3.
  - Writes 0x20–0x22 in cycles 5–7; the last byte_en is 0x0000FFFF.
  - `done_o` and `port_rdy_o` in cycle 8.
- vl=64, sew=0: exactly 2 rows, both with byte_en 0xFFFFFFFF.
- The same case with `rd_stall_i`=1 in cycles 2–3: row 1 is read in cycle 4 and `done_o` is delayed 2 cycles. A start pulse in cycle 3 is ignored.
- vl=0: `port_rdy_o` is low only in cycle 1, `done_o` is in cycle 2, and there are no `rd_vld_o` or `wr_vld_o`.
- vs1=0xFF, vl=16, sew=2: reads 0xFF then 0x00.
- `rstn` low in cycle 3 of a 5-row instruction: all outputs return to reset values asynchronously, with no `wr_vld_o` and no `done_o` afterwards.
